// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard/forwarding control:
// register aliases, halt FSM states and per-stage destination records.
package cpu_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] rw;
      logic       wr;
      logic       ld;
   } stage_rec_t;

   localparam stage_rec_t REC_NONE = '0;

   // Producer in stage r writes the register that the ID reader needs.
   function automatic logic hit(stage_rec_t r, logic use_r, logic [4:0] src);
      return use_r & r.wr & (r.rw != REG_ZERO) & (src == r.rw);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, forwarding-select generation and syscall halt
// sequencing for the 5-stage pipeline.
module hazard_fwd_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ra_id,
   input  logic [4:0]       rb_id,
   input  logic [4:0]       rw_id,
   input  logic             use_a_id,
   input  logic             use_b_id,
   input  logic             regwrite_id,
   input  logic             memread_id,
   input  logic             syscall_id,
   input  logic             j_bub,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             A_MEM,
   output logic             A_WB,
   output logic             B_MEM,
   output logic             B_WB,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = $clog2(DRAIN_CYC + 1);

   state_t     state;
   logic [DW-1:0] drain;
   stage_rec_t ex;
   stage_rec_t mem;
   stage_rec_t wb;

   logic lu;
   logic a_mem_n;
   logic a_wb_n;
   logic b_mem_n;
   logic b_wb_n;
   logic stall_inc;
   logic flush_inc;

   assign lu = ex.ld & (hit(ex, use_a_id, ra_id) | hit(ex, use_b_id, rb_id));

   // A load in EX cannot feed EX->EX; it is caught by lu instead.
   assign a_mem_n = hit(ex, use_a_id, ra_id) & ~ex.ld;
   assign a_wb_n  = ~a_mem_n & hit(mem, use_a_id, ra_id);
   assign b_mem_n = hit(ex, use_b_id, rb_id) & ~ex.ld;
   assign b_wb_n  = ~b_mem_n & hit(mem, use_b_id, rb_id);

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      unique case (state)
         RUN: begin
            if (j_bub) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu) begin
               idex_flush = 1'b1;
            end else begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
            end
         end
         DRAIN: idex_flush = 1'b1;
         default: ;
      endcase
   end

   assign flush_inc = (state == RUN) & j_bub;
   assign stall_inc = (state == RUN) & ~j_bub & lu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         drain  <= '0;
         halted <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (!j_bub && !lu && syscall_id) begin
                  state <= DRAIN;
                  drain <= DW'(DRAIN_CYC);
               end
            end
            DRAIN: begin
               drain <= drain - 1'b1;
               if (drain == DW'(1)) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: ;
            default: state <= RUN;
         endcase
      end
   end

   // Shadow records and selects freeze once the core is halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex    <= REC_NONE;
         mem   <= REC_NONE;
         wb    <= REC_NONE;
         A_MEM <= 1'b0;
         A_WB  <= 1'b0;
         B_MEM <= 1'b0;
         B_WB  <= 1'b0;
      end else if (state != HALT) begin
         ex    <= idex_flush ? REC_NONE
                             : '{rw: rw_id, wr: regwrite_id, ld: memread_id};
         mem   <= ex;
         wb    <= mem;
         A_MEM <= a_mem_n & ~idex_flush;
         A_WB  <= a_wb_n & ~idex_flush;
         B_MEM <= b_mem_n & ~idex_flush;
         B_WB  <= b_wb_n & ~idex_flush;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .clr (1'b0),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .clr (1'b0),
      .cnt (flush_cnt)
   );

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Control-side counterpart of the datapath forwarding/bubble multiplexers in the 5-stage pipelined MIPS core.
- Keeps shadow destination/write-enable/load records for the EX, MEM and WB stages, and detects load-use and taken-branch hazards.
- Produces the registered forwarding selects A_MEM/A_WB/B_MEM/B_WB for the instruction in EX, plus pipeline enable/flush controls.
- Sequences a syscall halt (drain, then freeze) and keeps saturating stall/flush statistics.

Parameters:
- CNT_W, 16, width of the stall and flush statistic counters.
- DRAIN_CYC, 3, cycles of bubble insertion after a syscall leaves ID before halted asserts.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high (fixed).
- ra_id  in  5  source register A of the instruction in ID (already muxed for shifts/syscall).
- rb_id  in  5  source register B of the instruction in ID.
- rw_id  in  5  destination of the instruction in ID (already 5'h1f for jal).
- use_a_id  in  1  instruction in ID reads ra_id.
- use_b_id  in  1  instruction in ID reads rb_id.
- regwrite_id  in  1  instruction in ID writes rw_id.
- memread_id  in  1  instruction in ID is a load.
- syscall_id  in  1  instruction in ID is syscall.
- j_bub  in  1  branch/jump taken, resolved in EX.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to nop.
- idex_flush  out  1  load bubble into ID/EX.
- A_MEM, A_WB, B_MEM, B_WB  out  1 each  forwarding selects for the EX-stage instruction.
- halted  out  1  core frozen by syscall.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset (async): state RUN; all shadow records invalid; forwarding selects 0; halted 0; counters 0; drain counter 0.
- Combinational outputs: pc_en, ifid_en, ifid_flush, idex_flush.
- Registered outputs: forwarding selects, halted, counters.
- Load-use detect, lu: ld_ex & wr_ex & rw_ex!=0 & ((use_a_id & ra_id==rw_ex) | (use_b_id & rb_id==rw_ex)).
- RUN, priority order:
  - j_bub: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1; flush_cnt+1. lu and syscall_id are ignored.
  - else lu: pc_en=0, ifid_en=0, idex_flush=1; stall_cnt+1. Exactly one bubble.
  - else syscall_id: normal advance, then go to DRAIN with counter=DRAIN_CYC.
  - else normal: pc_en=ifid_en=1, both flushes 0.
- DRAIN: pc_en=0, ifid_en=0, idex_flush=1; counter decrements each cycle; at 1 go to HALT. j_bub in DRAIN is ignored.
- HALT: halted=1; all enables 0, flushes 0, shadow records frozen. Only rst exits HALT.
- Shadow update each non-HALT cycle:
  - EX <= idex_flush ? invalid : {rw_id, regwrite_id, memread_id}.
  - MEM <= EX; WB <= MEM.
- Forwarding selects: computed at ID against the pre-update EX/MEM records, registered into EX.
  - A_MEM_next = use_a_id & wr_ex & !ld_ex & rw_ex!=0 & ra_id==rw_ex.
  - A_WB_next = !A_MEM_next & use_a_id & wr_mem & rw_mem!=0 & ra_id==rw_mem. This also covers a load in MEM.
  - B_MEM_next / B_WB_next are identical using rb_id / use_b_id.
  - All selects clear to 0 when idex_flush=1.
- WB-stage producer vs ID reader is not forwarded; the register file writes before it reads.
- Register $0 is never forwarded or stalled on.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package (cpu_pkg): REG_ZERO=5'd0, REG_RA=5'd31, FSM state encoding {RUN, DRAIN, HALT}, stage-record struct {rw[4:0], wr, ld}.
- One natural sub-module, sat_counter (parameter W, inputs inc/clr), instantiated twice.

Test Plan:
- Consumer follows add r3 with ra=3 -> one cycle later A_MEM=1, A_WB=0. With one unrelated instruction between -> A_WB=1, A_MEM=0.
- Back-to-back producers both writing r5, consumer rb=5 -> B_MEM=1 and B_WB=0 (MEM has priority).
- lw r4, then consumer with ra=4 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1. Next cycle consumer in EX with A_WB=1, A_MEM=0.
- j_bub=1 in the same cycle as a load-use match -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Writer to r0, then consumer ra=0 -> all selects 0, no stall. jal then consumer reading r31 -> A_MEM=1.
- syscall in ID -> 3 bubble cycles with pc_en=0, then halted=1 and held. Async rst mid-DRAIN -> halted=0, state RUN, counters 0 immediately.
